// File: rtl/sram_arb2_ctrl.sv
// -----------------------------------------------------------------------------
// sram_arb2_ctrl
//
// Two-requester arbiter and sequencer in front of one 4096x22 single-port
// register-file SRAM macro (rflp4096x22mx4). Each requester issues word
// read/write commands over a valid/ready handshake. At most one command is
// granted per cycle, and every macro pin is driven straight from a flop. Read
// data comes back on a per-requester response port two cycles after the
// command is accepted. Throughput is one access per cycle.
//
// Timeline for a command accepted at clock edge E0:
//   E0 : command registered onto the MEM_* pins (MEM_NCE=0)
//   E1 : macro samples its pins; writes commit, read data appears on MEM_DO
//   E2 : MEM_DO registered into RSPn_RDATA; RSPn_VALID is high for one cycle
//
// Configuration macro:
//   SRAM_ARB_FIXED_PRI_EN  defined   -> requester 0 always wins a conflict and
//                                       requester 1 can starve.
//                          undefined -> round robin. After each grant the
//                                       other requester gets priority.
//
// Ports:
//   CLK, NRST          clock (posedge) and asynchronous active-low reset
//   ARB_EN             1 = grants allowed; 0 = no new grants (reads that are
//                      already in flight still complete)
//   REQn_VALID/READY   command handshake, n = 0,1. A requester that is not
//                      granted must hold VALID and its payload stable.
//   REQn_WE            1 = write, 0 = read
//   REQn_ADDR          word address; [AW-1:2] -> MEM_RA, [1:0] -> MEM_CA
//   REQn_WDATA         write data
//   RSPn_VALID         one-cycle pulse; RSPn_RDATA holds read data
//   RSPn_RDATA         read data, held until the next response to n
//   MEM_RA/CA/DIN      macro address and data-in pins
//   MEM_NWRT, MEM_NCE  macro write strobe and chip enable (both active low)
//   MEM_DO             macro data-out
// -----------------------------------------------------------------------------
module sram_arb2_ctrl #(
    parameter int DW  = 22,
    parameter int AW  = 12,
    parameter int RAW = AW - 2
) (
    input  logic           CLK,
    input  logic           NRST,
    input  logic           ARB_EN,

    input  logic           REQ0_VALID,
    output logic           REQ0_READY,
    input  logic           REQ0_WE,
    input  logic [AW-1:0]  REQ0_ADDR,
    input  logic [DW-1:0]  REQ0_WDATA,

    input  logic           REQ1_VALID,
    output logic           REQ1_READY,
    input  logic           REQ1_WE,
    input  logic [AW-1:0]  REQ1_ADDR,
    input  logic [DW-1:0]  REQ1_WDATA,

    output logic           RSP0_VALID,
    output logic [DW-1:0]  RSP0_RDATA,
    output logic           RSP1_VALID,
    output logic [DW-1:0]  RSP1_RDATA,

    output logic [RAW-1:0] MEM_RA,
    output logic [1:0]     MEM_CA,
    output logic [DW-1:0]  MEM_DIN,
    output logic           MEM_NWRT,
    output logic           MEM_NCE,
    input  logic [DW-1:0]  MEM_DO
);

    // Tag carried alongside a read while it travels through the macro.
    typedef struct packed {
        logic vld;   // a read occupies this stage
        logic id;    // requester that issued it
    } rd_tag_t;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic           gnt0;
    logic           gnt1;
    logic           gnt_any;
    logic           gnt_id;
    logic           conflict_id;   // requester that wins when both are valid

    logic           sel_we;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_wdata;

`ifdef SRAM_ARB_FIXED_PRI_EN
    // Fixed priority: requester 0 wins every conflict. No pointer state.
    assign conflict_id = 1'b0;
`else
    // Round robin: after each grant, priority moves to the requester that did
    // not win. With no grant the pointer keeps its value.
    logic prio_q;

    // NOTE: state flops use non-blocking (<=) assignments so that every flop
    // samples the values from before the edge, whatever order the blocks run in.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            prio_q <= 1'b0;
        end else if (gnt_any) begin
            prio_q <= ~gnt_id;
        end
    end

    assign conflict_id = prio_q;
`endif

    // READY is gated by NRST so that no handshake can happen while reset is
    // asserted, even though the reset is asynchronous.
    always_comb begin
        // NOTE: every output of this block gets a default first. A path that
        // leaves an output unassigned would otherwise infer a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (NRST && ARB_EN) begin
            if (REQ0_VALID && REQ1_VALID) begin
                gnt0 = (conflict_id == 1'b0);
                gnt1 = (conflict_id == 1'b1);
            end else begin
                gnt0 = REQ0_VALID;
                gnt1 = REQ1_VALID;
            end
        end
    end

    assign REQ0_READY = gnt0;
    assign REQ1_READY = gnt1;
    assign gnt_any    = gnt0 | gnt1;
    assign gnt_id     = gnt1;

    // Command mux. Its output only matters when gnt_any is set.
    always_comb begin
        sel_we    = REQ0_WE;
        sel_addr  = REQ0_ADDR;
        sel_wdata = REQ0_WDATA;
        if (gnt1) begin
            sel_we    = REQ1_WE;
            sel_addr  = REQ1_ADDR;
            sel_wdata = REQ1_WDATA;
        end
    end

    // -------------------------------------------------------------------------
    // Macro pin registers (edge E0)
    // -------------------------------------------------------------------------
    // RA/CA/DIN load only on a grant. On idle cycles they keep their last
    // value, so the macro's address and data pins do not toggle while it is
    // deselected. The reset drives MEM_NCE high asynchronously, which stops
    // any access that is under way.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            MEM_NCE  <= 1'b1;
            MEM_NWRT <= 1'b1;
            MEM_RA   <= '0;
            MEM_CA   <= '0;
            MEM_DIN  <= '0;
        end else if (gnt_any) begin
            MEM_NCE  <= 1'b0;
            MEM_NWRT <= ~sel_we;
            MEM_RA   <= sel_addr[AW-1:2];
            MEM_CA   <= sel_addr[1:0];
            MEM_DIN  <= sel_wdata;
        end else begin
            MEM_NCE  <= 1'b1;
            MEM_NWRT <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Read pipe: two {valid,id} stages that track each read through the macro.
    // Stage 1 lines up with the pins being presented (E0 -> E1). Stage 2 lines
    // up with data coming out on MEM_DO (E1 -> E2). A new read can enter every
    // cycle. Reset clears both stages, so reads in flight are dropped without
    // a response.
    // -------------------------------------------------------------------------
    rd_tag_t rd_p1;
    rd_tag_t rd_p2;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            rd_p1 <= '0;
            rd_p2 <= '0;
        end else begin
            rd_p1.vld <= gnt_any & ~sel_we;
            rd_p1.id  <= gnt_id;
            rd_p2     <= rd_p1;
        end
    end

    // -------------------------------------------------------------------------
    // Response registers (edge E2)
    // -------------------------------------------------------------------------
    // Only one read occupies stage 2 at a time, so at most one RSPn_VALID is
    // high in any cycle. Each RDATA register loads only for its own
    // requester and otherwise holds its value.
    logic rsp0_hit;
    logic rsp1_hit;

    assign rsp0_hit = rd_p2.vld & ~rd_p2.id;
    assign rsp1_hit = rd_p2.vld &  rd_p2.id;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            RSP0_VALID <= 1'b0;
            RSP1_VALID <= 1'b0;
            RSP0_RDATA <= '0;
            RSP1_RDATA <= '0;
        end else begin
            RSP0_VALID <= rsp0_hit;
            RSP1_VALID <= rsp1_hit;
            if (rsp0_hit) begin
                RSP0_RDATA <= MEM_DO;
            end
            if (rsp1_hit) begin
                RSP1_RDATA <= MEM_DO;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Protocol properties (simulation only)
    // -------------------------------------------------------------------------
`ifndef SYNTHESIS
    // At most one grant per cycle.
    a_one_grant : assert property (@(posedge CLK) disable iff (!NRST)
        !(REQ0_READY && REQ1_READY));

    // A grant only goes to a requester that is asking.
    a_ready0_valid : assert property (@(posedge CLK) disable iff (!NRST)
        REQ0_READY |-> REQ0_VALID);
    a_ready1_valid : assert property (@(posedge CLK) disable iff (!NRST)
        REQ1_READY |-> REQ1_VALID);

    // No grants while arbitration is disabled.
    a_arb_off : assert property (@(posedge CLK) disable iff (!NRST)
        !ARB_EN |-> !(REQ0_READY || REQ1_READY));

    // The two response ports never pulse in the same cycle.
    a_rsp_excl : assert property (@(posedge CLK) disable iff (!NRST)
        !(RSP0_VALID && RSP1_VALID));

    // On a conflict, the requester holding priority wins.
    a_conflict : assert property (@(posedge CLK) disable iff (!NRST)
        (ARB_EN && REQ0_VALID && REQ1_VALID) |->
            (conflict_id ? REQ1_READY : REQ0_READY));
`endif

endmodule

// File: tb/tb_sram_arb2_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_arb2_ctrl
//
// Directed testbench for sram_arb2_ctrl with a behavioural model of the
// macro. The driver applies commands at the falling edge and samples READY
// just before the rising edge. When a read is accepted, the driver pushes the
// expected data and the expected response edge into a per-requester queue.
// Expected data comes from a reference array that tracks accepted writes. A
// separate monitor pops the queue and compares every time a response pulse
// appears.
// -----------------------------------------------------------------------------
module tb_sram_arb2_ctrl;

    localparam int DW  = 22;
    localparam int AW  = 12;
    localparam int RAW = 10;

    logic           CLK = 1'b0;
    logic           NRST;
    logic           ARB_EN;
    logic           REQ0_VALID, REQ0_READY, REQ0_WE;
    logic [AW-1:0]  REQ0_ADDR;
    logic [DW-1:0]  REQ0_WDATA;
    logic           REQ1_VALID, REQ1_READY, REQ1_WE;
    logic [AW-1:0]  REQ1_ADDR;
    logic [DW-1:0]  REQ1_WDATA;
    logic           RSP0_VALID, RSP1_VALID;
    logic [DW-1:0]  RSP0_RDATA, RSP1_RDATA;
    logic [RAW-1:0] MEM_RA;
    logic [1:0]     MEM_CA;
    logic [DW-1:0]  MEM_DIN;
    logic           MEM_NWRT, MEM_NCE;
    logic [DW-1:0]  MEM_DO;

    always #5 CLK = ~CLK;

    sram_arb2_ctrl #(.DW(DW), .AW(AW), .RAW(RAW)) dut (
        .CLK        (CLK),
        .NRST       (NRST),
        .ARB_EN     (ARB_EN),
        .REQ0_VALID (REQ0_VALID),
        .REQ0_READY (REQ0_READY),
        .REQ0_WE    (REQ0_WE),
        .REQ0_ADDR  (REQ0_ADDR),
        .REQ0_WDATA (REQ0_WDATA),
        .REQ1_VALID (REQ1_VALID),
        .REQ1_READY (REQ1_READY),
        .REQ1_WE    (REQ1_WE),
        .REQ1_ADDR  (REQ1_ADDR),
        .REQ1_WDATA (REQ1_WDATA),
        .RSP0_VALID (RSP0_VALID),
        .RSP0_RDATA (RSP0_RDATA),
        .RSP1_VALID (RSP1_VALID),
        .RSP1_RDATA (RSP1_RDATA),
        .MEM_RA     (MEM_RA),
        .MEM_CA     (MEM_CA),
        .MEM_DIN    (MEM_DIN),
        .MEM_NWRT   (MEM_NWRT),
        .MEM_NCE    (MEM_NCE),
        .MEM_DO     (MEM_DO)
    );

    // Macro model: samples its pins on the rising edge; read data follows that edge.
    logic [DW-1:0] macro_mem [4096];

    always @(posedge CLK) begin
        if (MEM_NCE == 1'b0) begin
            if (MEM_NWRT == 1'b0) macro_mem[{MEM_RA, MEM_CA}] <= MEM_DIN;
            else                  MEM_DO <= macro_mem[{MEM_RA, MEM_CA}];
        end
    end

    // Scoreboard
    typedef struct {
        logic [DW-1:0] data;
        int            due;    // edge count at which RSP_VALID is expected
    } exp_t;

    exp_t          q0[$];
    exp_t          q1[$];
    exp_t          mon_e;
    logic [DW-1:0] ref_mem [4096];
    int            edge_cnt = 0;
    int            n_checks = 0;
    int            n_pass   = 0;

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Response monitor
    always @(negedge CLK) begin
        if (NRST === 1'b1) begin
            if (RSP0_VALID === 1'b1 || RSP1_VALID === 1'b1)
                check("rsp_exclusive", {31'b0, RSP0_VALID & RSP1_VALID}, 32'd0);
            if (RSP0_VALID === 1'b1) begin
                if (q0.size() == 0) check("rsp0_unexpected", {31'b0, RSP0_VALID}, 32'd0);
                else begin
                    mon_e = q0.pop_front();
                    check("rsp0_rdata", {10'b0, RSP0_RDATA}, {10'b0, mon_e.data});
                    check("rsp0_latency", edge_cnt, mon_e.due);
                end
            end
            if (RSP1_VALID === 1'b1) begin
                if (q1.size() == 0) check("rsp1_unexpected", {31'b0, RSP1_VALID}, 32'd0);
                else begin
                    mon_e = q1.pop_front();
                    check("rsp1_rdata", {10'b0, RSP1_RDATA}, {10'b0, mon_e.data});
                    check("rsp1_latency", edge_cnt, mon_e.due);
                end
            end
        end
    end

    // One command cycle. Drive at the falling edge, sample READY 1 time unit
    // before the rising edge, then return 1 time unit after that edge.
    task automatic cycle(input logic v0, input logic we0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0,
                         input logic v1, input logic we1, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d1,
                         output logic g0, output logic g1);
        @(negedge CLK);
        REQ0_VALID = v0; REQ0_WE = we0; REQ0_ADDR = a0; REQ0_WDATA = d0;
        REQ1_VALID = v1; REQ1_WE = we1; REQ1_ADDR = a1; REQ1_WDATA = d1;
        #4;
        g0 = REQ0_READY;
        g1 = REQ1_READY;
        if (g0 === 1'b1) begin
            if (we0) ref_mem[a0] = d0;
            else     q0.push_back('{data: ref_mem[a0], due: edge_cnt + 3});
        end
        if (g1 === 1'b1) begin
            if (we1) ref_mem[a1] = d1;
            else     q1.push_back('{data: ref_mem[a1], due: edge_cnt + 3});
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            REQ0_VALID = 1'b0;
            REQ1_VALID = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic       g0, g1;
    logic [3:0] exp_g0, exp_g1;

    initial begin
`ifdef SRAM_ARB_FIXED_PRI_EN
        exp_g0 = 4'b1111;
        exp_g1 = 4'b0000;
`else
        exp_g0 = 4'b0101;
        exp_g1 = 4'b1010;
`endif
        for (int i = 0; i < 4096; i++) begin
            macro_mem[i] = '0;
            ref_mem[i]   = '0;
        end
        MEM_DO = '0;
        NRST = 1'b0; ARB_EN = 1'b1;
        REQ0_VALID = 1'b1; REQ0_WE = 1'b0; REQ0_ADDR = 12'h100; REQ0_WDATA = '0;
        REQ1_VALID = 1'b0; REQ1_WE = 1'b0; REQ1_ADDR = '0;      REQ1_WDATA = '0;

        // T1: reset state with REQ0 valid, then a grant after release
        repeat (3) @(negedge CLK);
        #1;
        check("t1_nce",        {31'b0, MEM_NCE},    32'd1);
        check("t1_nwrt",       {31'b0, MEM_NWRT},   32'd1);
        check("t1_ra",         {22'b0, MEM_RA},     32'd0);
        check("t1_din",        {10'b0, MEM_DIN},    32'd0);
        check("t1_ready0",     {31'b0, REQ0_READY}, 32'd0);
        check("t1_rsp0_valid", {31'b0, RSP0_VALID}, 32'd0);
        check("t1_rsp1_valid", {31'b0, RSP1_VALID}, 32'd0);
        @(negedge CLK);
        NRST = 1'b1;
        #4;
        g0 = REQ0_READY;
        check("t1_grant_after_rst", {31'b0, g0}, 32'd1);
        if (g0 === 1'b1) q0.push_back('{data: ref_mem[12'h100], due: edge_cnt + 3});
        @(posedge CLK);
        #1;
        check("t1_nce_active", {31'b0, MEM_NCE}, 32'd0);
        idle(1);

        // T2: write then read of the same address, back to back
        cycle(1'b1, 1'b1, 12'hABC, 22'h2A5A5A, 1'b0, 1'b0, '0, '0, g0, g1);
        check("t2_wr_grant", {31'b0, g0},       32'd1);
        check("t2_wr_nce",   {31'b0, MEM_NCE},  32'd0);
        check("t2_wr_nwrt",  {31'b0, MEM_NWRT}, 32'd0);
        check("t2_wr_din",   {10'b0, MEM_DIN},  32'h2A5A5A);
        check("t2_wr_ra",    {22'b0, MEM_RA},   32'h2AF);
        check("t2_wr_ca",    {30'b0, MEM_CA},   32'd0);
        cycle(1'b1, 1'b0, 12'hABC, '0, 1'b0, 1'b0, '0, '0, g0, g1);
        check("t2_rd_grant", {31'b0, g0},       32'd1);
        check("t2_rd_nwrt",  {31'b0, MEM_NWRT}, 32'd1);
        check("t2_rd_ra",    {22'b0, MEM_RA},   32'h2AF);
        idle(1);
        @(posedge CLK);
        #1;
        check("t2_idle_nce",   {31'b0, MEM_NCE}, 32'd1);
        check("t2_idle_ra_hold", {22'b0, MEM_RA}, 32'h2AF);

        // T3: conflicting reads every cycle. The last grant before the loop
        // goes to requester 1, so round robin starts with requester 0.
        cycle(1'b1, 1'b1, 12'h001, 22'h01111, 1'b0, 1'b0, '0, '0, g0, g1);
        check("t3_pre_wr0", {31'b0, g0}, 32'd1);
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'h002, 22'h02222, g0, g1);
        check("t3_pre_wr1", {31'b0, g1}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 12'h001, '0, 1'b1, 1'b0, 12'h002, '0, g0, g1);
            check($sformatf("t3_g0_%0d", i), {31'b0, g0}, {31'b0, exp_g0[i]});
            check($sformatf("t3_g1_%0d", i), {31'b0, g1}, {31'b0, exp_g1[i]});
        end
        idle(1);

        // T4: preload data=addr at addresses 0..15, then stream 16 reads from REQ1
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b1, 12'(i), 22'(i), 1'b0, 1'b0, '0, '0, g0, g1);
            check($sformatf("t4_wr_grant_%0d", i), {31'b0, g0}, 32'd1);
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'(i), '0, g0, g1);
            check($sformatf("t4_rd_grant_%0d", i), {31'b0, g1}, 32'd1);
        end
        idle(1);

        // T5: ARB_EN dropped while a read is in flight
        cycle(1'b1, 1'b0, 12'h005, '0, 1'b0, 1'b0, '0, '0, g0, g1);
        check("t5_rd_grant", {31'b0, g0}, 32'd1);
        ARB_EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 12'h006, '0, 1'b1, 1'b0, 12'h006, '0, g0, g1);
            check($sformatf("t5_no_g0_%0d", i), {31'b0, g0},      32'd0);
            check($sformatf("t5_no_g1_%0d", i), {31'b0, g1},      32'd0);
            check($sformatf("t5_nce_%0d", i),   {31'b0, MEM_NCE}, 32'd1);
        end
        ARB_EN = 1'b1;
        idle(1);

        // T6: reset pulse one cycle after a read is accepted
        cycle(1'b1, 1'b0, 12'h007, '0, 1'b0, 1'b0, '0, '0, g0, g1);
        check("t6_rd_grant", {31'b0, g0}, 32'd1);
        REQ0_VALID = 1'b0;
        @(posedge CLK);
        #2;
        NRST = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        check("t6_async_nce",  {31'b0, MEM_NCE},  32'd1);
        check("t6_async_nwrt", {31'b0, MEM_NWRT}, 32'd1);
        REQ0_VALID = 1'b1;
        #1;
        check("t6_ready_in_rst", {31'b0, REQ0_READY}, 32'd0);
        REQ0_VALID = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        NRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("t6_no_rsp0_%0d", i), {31'b0, RSP0_VALID}, 32'd0);
            check($sformatf("t6_no_rsp1_%0d", i), {31'b0, RSP1_VALID}, 32'd0);
        end
        // The pointer restarts at 0, and data written before the reset is still there.
        cycle(1'b1, 1'b0, 12'h007, '0, 1'b1, 1'b0, 12'hABC, '0, g0, g1);
        check("t6_post_g0", {31'b0, g0}, 32'd1);
        check("t6_post_g1", {31'b0, g1}, 32'd0);
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'hABC, '0, g0, g1);
        check("t6_post_g1b", {31'b0, g1}, 32'd1);
        idle(6);

        check("end_q0_empty", q0.size(), 32'd0);
        check("end_q1_empty", q1.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
